add_pipe: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control.

---
 rtl/add_pipe_pkg.sv | 26 ++
 rtl/add_pipe_if.sv | 39 +++
 rtl/add_pipe_seg.sv | 42 ++++
 rtl/add_pipe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// ---------------------------------------------------------------------------
// add_pkg
//   Shared constants and derivation helpers for the pipelined adder slice.
//   Both the RTL and the bench reference model take segment width and
//   latency from here, so they cannot drift apart.
//
//   MODE_ADD / MODE_SUB : values of the 'sub' operand-mode bit
//   segWidth()          : bits handled by one pipeline segment
//   pipeLatency()       : cycles from accepted beat to out_valid (no stall)
// ---------------------------------------------------------------------------
package add_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int segWidth(input int width, input int stages);
        return width / stages;
    endfunction

    // Each segment owns exactly one register stage, so latency equals the
    // segment count.
    function automatic int pipeLatency(input int stages);
        return stages;
    endfunction

endpackage

// File: rtl/add_pipe_if.sv
// ---------------------------------------------------------------------------
// add_pipe_if
//   Operand/result handshake bundle for add_pipe.
//
//   in_valid / in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid / out_ready : result beat handshake (sum, cout, ovf)
//
//   master : the side producing operands and consuming results
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface add_pipe_if
    import add_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/add_pipe_seg.sv
// ---------------------------------------------------------------------------
// add_seg
//   Combinational SEG-bit ripple of full-adder cells: one pipeline segment.
//
//   i_a, i_b : segment operand bits (i_b already inverted for subtract)
//   i_ci     : carry into the segment LSB
//   o_s      : segment sum bits
//   o_co     : carry out of the segment MSB
//   o_cMsb   : carry INTO the segment MSB; the top segment's value XOR its
//              carry-out gives two's-complement overflow
// ---------------------------------------------------------------------------
module add_seg
    import add_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_ci,
    output logic [SEG-1:0] o_s,
    output logic           o_co,
    output logic           o_cMsb
);

    // The carry is walked through a procedural variable rather than a wire
    // vector so the chain does not look like a combinational self-loop.
    always_comb begin
        logic carry;
        carry  = i_ci;
        o_s    = '0;
        o_cMsb = 1'b0;
        for (int i = 0; i < SEG; i++) begin
            if (i == SEG - 1) begin
                o_cMsb = carry;
            end
            o_s[i] = i_a[i] ^ i_b[i] ^ carry;
            carry  = (i_a[i] & i_b[i]) | (carry & (i_a[i] ^ i_b[i]));
        end
        o_co = carry;
    end

endmodule

// File: rtl/add_pipe.sv
// ---------------------------------------------------------------------------
// add_pipe
//   Pipelined ripple-carry adder/subtractor with valid/ready flow control.
//   The WIDTH-bit carry chain is cut into STAGES registered segments of
//   SEG = WIDTH/STAGES bits. Latency is STAGES cycles, throughput 1 beat/cycle.
//
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; discards every in-flight beat
//   bus   : add_pipe_if slave (in_valid/in_ready/a/b/cin/sub in,
//           out_valid/out_ready/sum/cout/ovf out); its WIDTH must match
//
//   sub=0 : sum = a + b + cin,  cout = carry out
//   sub=1 : sum = a - b - cin,  cout = 1 when no borrow
// ---------------------------------------------------------------------------
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      reset,
    add_pipe_if.slave bus
);

    localparam int SEG   = segWidth(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;
    localparam int NSKEW = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gBadParams
        $error("add_pipe: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
    end

    logic             w_stall;
    logic [WIDTH-1:0] w_bEff;
    logic             w_cin0;
    logic             r_ovf;

    // Per-stage pipeline state; element k is the register after segment k.
    logic             r_valid [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];

    // Operand skew registers: element k carries the not-yet-added upper
    // operand bits from stage k to stage k+1.
    logic [WIDTH-1:0] r_a [NSKEW];
    logic [WIDTH-1:0] r_b [NSKEW];

    // A stall freezes the whole pipe, so nothing ever overtakes the blocked
    // output beat and no bubble can be squeezed out mid-stall.
    assign w_stall      = r_valid[LAST] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // Subtraction is A + ~B + ~borrow; the inversion happens once at the
    // input so later stages never need the mode bit.
    assign w_bEff = (bus.sub == MODE_SUB) ? ~bus.b   : bus.b;
    assign w_cin0 = (bus.sub == MODE_SUB) ? ~bus.cin : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic             w_validIn;
        logic             w_ci;
        logic [WIDTH-1:0] w_aIn;
        logic [WIDTH-1:0] w_bIn;
        logic [WIDTH-1:0] w_sumIn;
        logic [WIDTH-1:0] w_sumNext;
        logic [SEG-1:0]   w_sliceS;
        logic             w_co;
        logic             w_cMsb;

        if (k == 0) begin : gHead
            assign w_validIn = bus.in_valid;
            assign w_aIn     = bus.a;
            assign w_bIn     = w_bEff;
            assign w_ci      = w_cin0;
            assign w_sumIn   = '0;
        end else begin : gBody
            assign w_validIn = r_valid[k-1];
            assign w_aIn     = r_a[k-1];
            assign w_bIn     = r_b[k-1];
            assign w_ci      = r_carry[k-1];
            assign w_sumIn   = r_sum[k-1];
        end

        add_seg #(
            .SEG (SEG)
        ) uSeg (
            .i_a    (w_aIn[k*SEG +: SEG]),
            .i_b    (w_bIn[k*SEG +: SEG]),
            .i_ci   (w_ci),
            .o_s    (w_sliceS),
            .o_co   (w_co),
            .o_cMsb (w_cMsb)
        );

        // Lower result slices ride along unchanged; this stage fills its own.
        always_comb begin
            w_sumNext                = w_sumIn;
            w_sumNext[k*SEG +: SEG]  = w_sliceS;
        end

        // The valid bit moves with its data so a bubble stays a bubble.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
            end else if (!w_stall) begin
                r_valid[k] <= w_validIn;
                r_carry[k] <= w_co;
                r_sum[k]   <= w_sumNext;
            end
        end

        if (k < LAST) begin : gSkew
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                end else if (!w_stall) begin
                    r_a[k] <= w_aIn;
                    r_b[k] <= w_bIn;
                end
            end
        end else begin : gTail
            // Signed overflow: carry into the MSB disagrees with carry out.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= w_co ^ w_cMsb;
                end
            end
        end
    end

    assign bus.out_valid = r_valid[LAST];
    assign bus.sum       = r_sum[LAST];
    assign bus.cout      = r_carry[LAST];
    assign bus.ovf       = r_ovf;

endmodule
